// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - framed unsigned multiply-accumulate with valid/ready handshakes
// Sums up to N_MAX product terms per frame and holds the result until downstream takes it.
module mac_accumulator #(
    parameter int P     = 8,
    parameter int ACC_W = 16,
    parameter int N_MAX = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [P-1:0]                 i_product,
    input  logic                         i_in_last,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [ACC_W-1:0]             o_acc_out,
    output logic                         o_overflow,
    output logic [$clog2(N_MAX+1)-1:0]   o_term_count
);

    localparam int CNT_W   = $clog2(N_MAX + 1);
    localparam bit ONE_TERM = (N_MAX == 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry_out;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_frame_end;

    assign w_prod_ext  = ACC_W'(i_product);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_frame_end = i_in_last || (w_cnt_inc == CNT_W'(N_MAX));

    // Carry-in is zero; the final carry feeds the sticky overflow flag.
    always_comb begin : ripple_add
        logic v_c;
        v_c   = 1'b0;
        w_sum = '0;
        for (int i = 0; i < ACC_W; i++) begin
            w_sum[i] = r_acc[i] ^ w_prod_ext[i] ^ v_c;
            v_c      = (r_acc[i] & w_prod_ext[i]) | (v_c & (r_acc[i] ^ w_prod_ext[i]));
        end
        w_carry_out = v_c;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (w_accept) begin
                    w_next_state = (i_in_last || ONE_TERM) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                o_in_ready = 1'b1;
                if (w_accept && w_frame_end) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Result registers only move on an accept, so they stay frozen through HOLD and the idle gap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_acc <= w_prod_ext;
                r_ovf <= 1'b0;
                r_cnt <= CNT_W'(1);
            end else begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_carry_out;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_acc_out    = r_acc;
    assign o_overflow   = r_ovf;
    assign o_term_count = r_cnt;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - scoreboard bench for mac_accumulator
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_last, out_ready;
    logic [7:0]  product;
    logic        in_ready, out_valid, overflow;
    logic [15:0] acc_out;
    logic [3:0]  term_count;

    logic        v8, l8, or8;
    logic [7:0]  p8;
    logic        ir8, ov8, ovf8;
    logic [7:0]  acc8;
    logic [3:0]  cnt8;

    always #5 clk = ~clk;

    mac_accumulator #(.P(8), .ACC_W(16), .N_MAX(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_product(product), .i_in_last(in_last), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_acc_out(acc_out), .o_overflow(overflow),
        .o_term_count(term_count)
    );

    mac_accumulator #(.P(8), .ACC_W(8), .N_MAX(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(v8), .o_in_ready(ir8),
        .i_product(p8), .i_in_last(l8), .o_out_valid(ov8),
        .i_out_ready(or8), .o_acc_out(acc8), .o_overflow(ovf8),
        .o_term_count(cnt8)
    );

    typedef struct {
        logic [15:0] acc;
        int          cnt;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_frames = 0;
    logic [15:0] m_acc    = '0;
    int          m_cnt    = 0;
    logic        m_ovf    = 1'b0;
    bit          rand_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Independent reference: a frame ends on In_Last or on the 8th term.
    task automatic model_accept(input logic [7:0] prod, input bit last);
        logic [16:0] s;
        if (m_cnt == 0) begin
            m_acc = 16'(prod);
            m_ovf = 1'b0;
            m_cnt = 1;
        end else begin
            s     = {1'b0, m_acc} + 17'(prod);
            m_acc = s[15:0];
            m_ovf = m_ovf | s[16];
            m_cnt++;
        end
        if (last || m_cnt == 8) begin
            sb.push_back('{acc: m_acc, cnt: m_cnt, ovf: m_ovf});
            n_frames++;
            m_cnt = 0;
        end
    endtask

    task automatic drive_term(input logic [7:0] prod, input bit last, input int gap);
        int t;
        repeat (gap) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom);
            product  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        product  = prod;
        in_last  = last;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_accept(prod, last);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                e = sb.pop_front();
                check("acc_out", 32'(acc_out), 32'(e.acc));
                check("term_count", 32'(term_count), 32'(e.cnt));
                check("overflow", 32'(overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; product = '0; out_ready = 1'b1;
        v8 = 1'b0; l8 = 1'b0; p8 = '0; or8 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_acc", 32'(acc_out), 0);
        check("rst_cnt", 32'(term_count), 0);
        check("rst_ovf", 32'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        drive_term(8'd10, 1'b0, 0);
        drive_term(8'd20, 1'b0, 0);
        drive_term(8'd30, 1'b1, 0);
        @(negedge clk);
        check("latency_out_valid", 32'(out_valid), 1);
        @(posedge clk); #1;

        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive_term(8'd255, 1'b0, 0);
        @(negedge clk);
        check("full_out_valid", 32'(out_valid), 1);
        in_valid = 1'b1; product = 8'd99; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_acc_stable", 32'(acc_out), 2040);
            check("hold_cnt_stable", 32'(term_count), 8);
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hold_idle_valid", 32'(out_valid), 0);
        check("post_hold_idle_ready", 32'(in_ready), 1);
        check("post_hold_acc_kept", 32'(acc_out), 2040);

        @(posedge clk); #1;
        v8 = 1'b1; p8 = 8'd200; l8 = 1'b0;
        @(posedge clk); #1;
        p8 = 8'd100; l8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; l8 = 1'b0;
        @(negedge clk);
        check("w8_out_valid", 32'(ov8), 1);
        check("w8_acc", 32'(acc8), 44);
        check("w8_ovf", 32'(ovf8), 1);
        check("w8_cnt", 32'(cnt8), 2);
        @(posedge clk); #1;

        drive_term(8'd5, 1'b0, 0);
        drive_term(8'd6, 1'b0, 0);
        rst = 1'b1; in_valid = 1'b1; product = 8'd50; in_last = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        check("midrst_cnt", 32'(term_count), 0);
        check("midrst_acc", 32'(acc_out), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        drive_term(8'd7, 1'b1, 0);
        @(negedge clk);
        check("after_rst_valid", 32'(out_valid), 1);
        @(posedge clk); #1;

        n_frames  = 0;
        rand_done = 1'b0;
        fork
            begin
                while (n_frames < 1000) begin
                    drive_term(8'($urandom), ($urandom_range(0, 4) == 0),
                               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
